adc_pulse_gen: RTL

Synthesizable ADC-stream source that emulates the RF Data Converter AXI4-Stream output feeding the minimum trigger (`MM_trg`). It emits baseline-noise words interleaved with programmable two-step pulses: a first peak followed by a second peak. Each pulse start is time-stamped against the system `CURRENT_TIME`. It is used for on-chip trigger self-test, replacing the ADC input of `MM_trg` through a mux.

---
 rtl/adc_pulse_gen_pkg.sv | 11 +
 rtl/adc_noise_lfsr.sv | 23 ++
 rtl/adc_pulse_gen.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/adc_pulse_gen_pkg.sv
// adc_pulse_gen_pkg: state encoding and lane helpers shared by adc_pulse_gen and its noise LFSR.
package adc_pulse_gen_pkg;
  typedef enum logic [2:0] {IDLE, NOISE, FST, SND, DONE} state_e;
  localparam int SAMPLE_PER_TDATA = 8;
  function automatic logic [15:0] lane_pack(input logic [11:0] v);
    return {v, 4'h0};
  endfunction
  function automatic logic [11:0] sat13(input logic signed [12:0] s);
    return (s > 13'sd2047) ? 12'h7ff : (s < -13'sd2048) ? 12'h800 : s[11:0];
  endfunction
endpackage

// File: rtl/adc_noise_lfsr.sv
// adc_noise_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 0xACE1) decoded into per-lane -1/0/+1 offsets.
module adc_noise_lfsr
  import adc_pulse_gen_pkg::*;
#(
  parameter int LANES = SAMPLE_PER_TDATA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_i,
  output logic [LANES-1:0][1:0] delta_o
);
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = step_i ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hace1;
    else lfsr_q <= lfsr_d;
  end
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [1:0] code;
    assign code = lfsr_q[(2*j)%16 +: 2];
    assign delta_o[j] = (code == 2'd1) ? 2'b01 : (code == 2'd2) ? 2'b11 : 2'b00;
  end
endmodule

// File: rtl/adc_pulse_gen.sv
// adc_pulse_gen: AXI4-Stream ADC emulator emitting baseline noise and two-step pulses for trigger self-test.
// Define ADC_PULSE_GEN_LFSR_NOISE_EN for LFSR-driven noise instead of the fixed alternating +-1 pattern.
module adc_pulse_gen
  import adc_pulse_gen_pkg::*;
#(
  parameter int TDATA_WIDTH          = 128,
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int CNT_WIDTH            = 16,
  parameter int TIME_STAMP_WIDTH     = 48
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            ENABLE,
  input  logic [CNT_WIDTH-1:0]            NUM_PULSES,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] FST_HEIGHT,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] SND_HEIGHT,
  input  logic [CNT_WIDTH-1:0]            FST_WIDTH,
  input  logic [CNT_WIDTH-1:0]            SND_WIDTH,
  input  logic [CNT_WIDTH-1:0]            INTERVAL,
  input  logic [TIME_STAMP_WIDTH-1:0]     CURRENT_TIME,
  input  logic                            TREADY,
  output logic [TDATA_WIDTH-1:0]          TDATA,
  output logic                            TVALID,
  output logic                            PULSE_START,
  output logic [TIME_STAMP_WIDTH-1:0]     PULSE_TIME,
  output logic [CNT_WIDTH-1:0]            PULSE_CNT,
  output logic                            BUSY
);
  localparam int SPT = TDATA_WIDTH / 16;
  localparam logic [CNT_WIDTH-1:0] ONE = 1;
  state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, pcnt_q, pcnt_d, np_q, fw_q, sw_q, iv_q;
  logic [ADC_RESOLUTION_WIDTH-1:0] base_q, fh_q, sh_q;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d, noise_w;
  logic [TIME_STAMP_WIDTH-1:0] ptime_q;
  logic tvalid_q, tvalid_d, pstart_q, pstart_d, adv, eop;
  logic signed [12:0] base13;
  assign base13 = {base_q[11], base_q};
`ifdef ADC_PULSE_GEN_LFSR_NOISE_EN
  logic [SPT-1:0][1:0] delta;
  adc_noise_lfsr #(.LANES(SPT)) u_lfsr (
    .clk    (CLK),
    .rst    (RESET),
    .step_i (tvalid_q & TREADY),
    .delta_o(delta)
  );
  for (genvar j = 0; j < SPT; j++) begin : g_lane
    assign noise_w[16*j +: 16] = lane_pack(sat13(base13 + $signed({{11{delta[j][1]}}, delta[j]})));
  end
`else
  for (genvar j = 0; j < SPT; j++) begin : g_lane
    assign noise_w[16*j +: 16] = lane_pack(sat13(base13 + ((j % 2 == 1) ? 13'sd1 : -13'sd1)));
  end
`endif
  // The sequencer advances each time a new word enters the output register.
  always_comb begin
    adv = !tvalid_q || TREADY;
    state_d = state_q;
    cnt_d = cnt_q;
    pcnt_d = pcnt_q;
    tdata_d = tdata_q;
    tvalid_d = tvalid_q;
    pstart_d = 1'b0;
    eop = 1'b0;
    case (state_q)
      IDLE: begin
        tvalid_d = tvalid_q && !TREADY;
        if (ENABLE) begin
          state_d = (INTERVAL == '0) ? FST : NOISE;
          cnt_d = '0;
          pcnt_d = '0;
        end
      end
      NOISE, DONE: begin
        if (!ENABLE) begin
          state_d = IDLE;
          tvalid_d = 1'b0;
        end else if (adv) begin
          tdata_d = noise_w;
          tvalid_d = 1'b1;
          cnt_d = cnt_q + ONE;
          if (state_q == NOISE && cnt_q + ONE == iv_q) begin
            state_d = FST;
            cnt_d = '0;
          end
        end
      end
      FST: if (adv) begin
        tdata_d = {SPT{lane_pack(fh_q)}};
        tvalid_d = 1'b1;
        pstart_d = cnt_q == '0;
        cnt_d = cnt_q + ONE;
        if (cnt_q + ONE >= fw_q) begin
          if (sw_q == '0) eop = 1'b1;
          else begin
            state_d = SND;
            cnt_d = '0;
          end
        end
      end
      SND: if (adv) begin
        tdata_d = {SPT{lane_pack(sh_q)}};
        tvalid_d = 1'b1;
        cnt_d = cnt_q + ONE;
        eop = cnt_q + ONE == sw_q;
      end
      default: state_d = IDLE;
    endcase
    if (eop) begin
      pcnt_d = pcnt_q + ONE;
      cnt_d = '0;
      state_d = (np_q != '0 && pcnt_d == np_q) ? DONE : !ENABLE ? IDLE : (iv_q == '0) ? FST : NOISE;
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pcnt_q <= '0;
      tdata_q <= '0;
      tvalid_q <= 1'b0;
      pstart_q <= 1'b0;
      ptime_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pcnt_q <= pcnt_d;
      tdata_q <= tdata_d;
      tvalid_q <= tvalid_d;
      pstart_q <= pstart_d;
      if (pstart_d) ptime_q <= CURRENT_TIME;
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      np_q <= '0;
      fw_q <= '0;
      sw_q <= '0;
      iv_q <= '0;
      base_q <= '0;
      fh_q <= '0;
      sh_q <= '0;
    end else if (state_q == IDLE && ENABLE) begin
      np_q <= NUM_PULSES;
      fw_q <= FST_WIDTH;
      sw_q <= SND_WIDTH;
      iv_q <= INTERVAL;
      base_q <= BASELINE;
      fh_q <= FST_HEIGHT;
      sh_q <= SND_HEIGHT;
    end
  end
  assign TDATA = tdata_q;
  assign TVALID = tvalid_q;
  assign PULSE_START = pstart_q;
  assign PULSE_TIME = ptime_q;
  assign PULSE_CNT = pcnt_q;
  assign BUSY = state_q != IDLE;
endmodule
